// File: rtl/tdm_mux8_if.sv
// Bundle of framing controls, channel words and serial slot outputs for the 8-channel TDM transmitter.
// The master side drives start/stop/D0..D7; the slave side (the transmitter) drives the slot outputs.
interface tdm_mux8_if #(parameter int W = 1);
  logic         start;
  logic         stop;
  logic [W-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [W-1:0] Y;
  logic [2:0]   S;
  logic         SYNC;
  logic         BUSY;
  logic [7:0]   FRAME_CNT;

  modport master (
    output start, stop, D0, D1, D2, D3, D4, D5, D6, D7,
    input  Y, S, SYNC, BUSY, FRAME_CNT
  );

  modport slave (
    input  start, stop, D0, D1, D2, D3, D4, D5, D6, D7,
    output Y, S, SYNC, BUSY, FRAME_CNT
  );
endinterface

// File: rtl/tdm_mux8.sv
// Eight-channel TDM transmitter: buffers a frame of eight words and emits one slot per clock
// with slot index and frame sync, running back-to-back frames until a stop request is seen.
module tdm_mux8 #(
  parameter int W = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_mux8_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_next;
  logic [W-1:0] frame_buf [8];
  logic [W-1:0] d_in [8];
  logic [2:0]   slot, slot_next;
  logic         stop_flag, stop_flag_next;
  logic [7:0]   frame_cnt;
  logic         load, frame_done;

  assign d_in[0] = bus.D0;
  assign d_in[1] = bus.D1;
  assign d_in[2] = bus.D2;
  assign d_in[3] = bus.D3;
  assign d_in[4] = bus.D4;
  assign d_in[5] = bus.D5;
  assign d_in[6] = bus.D6;
  assign d_in[7] = bus.D7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A stop seen at the slot-7 edge itself ends framing there, hence stop_flag || stop.
  always_comb begin
    state_next     = state;
    slot_next      = slot;
    stop_flag_next = stop_flag;
    load           = 1'b0;
    frame_done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          slot_next  = 3'd0;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (slot == 3'd7) begin
          frame_done = 1'b1;
          slot_next  = 3'd0;
          if (stop_flag || bus.stop) begin
            state_next     = IDLE;
            stop_flag_next = 1'b0;
          end else begin
            load = 1'b1;
          end
        end else begin
          slot_next      = slot + 3'd1;
          stop_flag_next = stop_flag || bus.stop;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= 3'd0;
      stop_flag <= 1'b0;
      frame_cnt <= 8'd0;
      for (int i = 0; i < 8; i++) frame_buf[i] <= '0;
    end else begin
      slot      <= slot_next;
      stop_flag <= stop_flag_next;
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      if (load) begin
        for (int i = 0; i < 8; i++) frame_buf[i] <= d_in[i];
      end
    end
  end

  // Outputs come only from registers so the downstream demux sees no input-to-output path.
  always_comb begin
    bus.Y    = '0;
    bus.S    = 3'd0;
    bus.SYNC = 1'b0;
    bus.BUSY = 1'b0;
    if (state == RUN) begin
      bus.Y    = frame_buf[slot];
      bus.S    = slot;
      bus.SYNC = (slot == 3'd0);
      bus.BUSY = 1'b1;
    end
  end

  assign bus.FRAME_CNT = frame_cnt;

endmodule
